pixel_repacker: RTL
===================

# pixel_repacker

Output stage directly downstream of the slice multiplexer, in the `clk_out_int` domain. It receives 4-pixel words whose valid masks may be partial at chunk ends, and compacts them into dense 4-pixel words. Line and frame boundaries are regenerated from `frame_width` and `frame_height`, so the display interface sees gap-free lines with exact EOL/EOF and a partial mask only on the last word of each line.

## Interface
- `MAX_FRAME_WIDTH`, default 5120: maximum picture width in pixels; sizes the pixel counter.
- `BUF_PIXS`, default 12: capacity of the pixel buffer, in pixels.
- `clk_out_int`  in  1  pixel output clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear of all state.
- `frame_width`  in  16  pixels per line, 1..MAX_FRAME_WIDTH.
- `frame_height`  in  16  lines per frame, ≥1.
- `pixs_in`  in  168  4 pixels × 3 comps × 14 b; pixel p, comp c at [(p*3+c)*14 +: 14].
- `pixs_in_valid`  in  4  pixel valid mask; legal values 0000/0001/0011/0111/1111.
- `pixs_in_sof`  in  1  start-of-frame pulse; precedes the frame's first valid word.
- `pixs_out`  out  168  compacted pixels, same packing as `pixs_in`.
- `pixs_out_valid`  out  4  output mask; 1111 except on the last word of a line.
- `pixs_out_sof`  out  1  high with the first output word of the frame.
- `pixs_out_eol`  out  1  high with the last word of each line.
- `pixs_out_eof`  out  1  high with the last word of the frame.
- `err_mask`  out  1  sticky: an illegal (non-contiguous) input mask was seen.
- `err_overflow`  out  1  sticky: an input word was dropped because the buffer was full.

## Operation
- Buffer: `BUF_PIXS` pixel slots in FIFO order plus occupancy `cnt` (0..BUF_PIXS).
- Line counters: pixel counter `pix_cnt` (0..frame_width-1) and line counter `line_cnt`.
- `rem` = frame_width − pix_cnt. `need` = min(4, rem).
- Emit step, evaluated every cycle on the pre-append buffer:
  - If cnt ≥ need, pop `need` pixels into slots 0..need-1 of `pixs_out`.
  - Unused output slots are driven 0.
  - `pixs_out_valid` = (1<<need)−1.
  - pix_cnt += need.
- End of line (need == rem on an emit):
  - Assert eol; pix_cnt←0; line_cnt++.
  - If line_cnt == frame_height−1, also assert eof and set line_cnt←0.
- Append step, after the emit:
  - Input pixels 0..n−1 are appended, where n = popcount(`pixs_in_valid`).
  - Pixels that belong to the next line stay in the buffer and start that line.
- Illegal input mask: set `err_mask`, then append the pixels in the lowest contiguous run of set bits starting at bit 0.
- Overflow: if (cnt after the emit) + n > BUF_PIXS:
  - Drop the whole input word.
  - Set `err_overflow`.
  - Counters are unaffected.
- SOF: `pixs_in_sof` clears the buffer, both counters and the error flags, then sets `sof_pend`. The first emitted word carries `pixs_out_sof` and clears `sof_pend`.
- `pixs_in_valid` ≠ 0 in the same cycle as `pixs_in_sof` is treated as the new frame's first word: clear first, then append.
- `flush` is equivalent to reset but synchronous. It has priority over `pixs_in_sof` and over data.

## Timing
- Reset and flush values:
  - `pixs_out`, `pixs_out_valid`, `pixs_out_sof`, `pixs_out_eol`, `pixs_out_eof` all 0.
  - `err_*` = 0, `cnt` = 0, counters = 0, `sof_pend` = 0.
- All outputs are registered.
- Latency: a word sampled at edge k can appear on the outputs at the earliest after edge k+1 (2-cycle pipeline). This applies when it completes `need`.
- Output rate is at most one word per cycle, with no backpressure in either direction.
- `pixs_out_sof`/`eol`/`eof` are single-cycle pulses, each aligned with its word's `pixs_out_valid` ≠ 0.
- Idle cycles with no emit drive `pixs_out_valid` = 0 and all flags 0.
- frame_width = 1: every emit carries 0001 and eol. frame_height = 1: every eol also carries eof.

## Structure
- Shared package:
  - PIX_BITS = 14, NCOMP = 3, PIXS_PER_WORD = 4, WORD_BITS = 168.
  - Function `mask_to_cnt` (mask → contiguous count, plus illegal flag).
- One sub-module, `pix_shift_buf`, holds the buffer:
  - Inputs: pop count (0..4) and push count (0..4) with push data.
  - Outputs: head 4 pixels and `cnt`.
- The line/frame counters, emit decision and flags stay in the top module.

## Test plan
- Width 10, height 2. Input masks 1111, 1111, 0011 per line, one word every 2 cycles → outputs 1111, 1111, 0011+eol per line. The 6th word carries eof.
- Width 10 built from two 5-pixel chunks. Inputs 1111, 0001, 1111, 0001 → outputs 1111, 1111, 0011+eol.
- Width 6, height 1, back-to-back inputs 1111, 1111, 1111 → outputs 1111, 0011+eol+eof, 1111. The third output's pixels are the first 4 of the next line.
- Width 1, inputs 1111 every cycle. Occupancy after appends: 4, 7, 10, then 13 > 12, so the 4th word is dropped and `err_overflow` = 1. Every output is 0001+eol.
- Input mask 0101 → `err_mask` = 1 and exactly 1 pixel is appended. A following `pixs_in_sof` clears `err_mask`.
- Reset asserted mid-line with cnt = 5 → all outputs are 0 immediately. After release, a new SOF plus a 1111 word yields a first output with `pixs_out_sof` = 1.

Source files
------------

// File: rtl/pixel_repacker_pkg.sv
// -----------------------------------------------------------------------------
// pixel_repacker_pkg
// Shared definitions for the pixel repacker output stage: pixel and word
// geometry, and the input-mask decoder used to count appended pixels.
// -----------------------------------------------------------------------------
package pixel_repacker_pkg;

   localparam int PIX_BITS      = 14;                       // bits per component
   localparam int NCOMP         = 3;                        // components per pixel
   localparam int PIXS_PER_WORD = 4;                        // pixels per word
   localparam int PIX_W         = PIX_BITS * NCOMP;         // 42 bits per pixel
   localparam int WORD_BITS     = PIX_W * PIXS_PER_WORD;    // 168 bits per word

   typedef logic [PIX_W-1:0] pix_t;
   typedef logic [2:0]       pix_num_t;                     // 0..4 pixels

   typedef struct packed {
      pix_num_t n;        // pixels in the lowest contiguous run from bit 0
      logic     illegal;  // mask was not one of 0000/0001/0011/0111/1111
   } mask_info_t;

   // Legal masks are a run of ones starting at bit 0. Anything else is
   // flagged, and only its lowest contiguous run from bit 0 is kept.
   function automatic mask_info_t mask_to_cnt(input logic [3:0] mask);
      mask_info_t r;
      r.illegal = 1'b0;
      case (mask)
         4'b0000: r.n = 3'd0;
         4'b0001: r.n = 3'd1;
         4'b0011: r.n = 3'd2;
         4'b0111: r.n = 3'd3;
         4'b1111: r.n = 3'd4;
         default: begin
            r.illegal = 1'b1;
            if (!mask[0])      r.n = 3'd0;
            else if (!mask[1]) r.n = 3'd1;
            else if (!mask[2]) r.n = 3'd2;
            else               r.n = 3'd3;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pix_shift_buf.sv
// -----------------------------------------------------------------------------
// pix_shift_buf
// FIFO-ordered pixel buffer. Each cycle it pops pop_cnt pixels from the head,
// then appends push_cnt pixels from push_data behind the survivors. Slot 0
// (LSBs) is the oldest pixel.
//
// Ports:
//   clk_out_int  pixel clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear, applied before the push of the same cycle
//   pop_cnt      pixels removed from the head (0..4, never more than cnt)
//   push_cnt     pixels appended from push_data slots 0..push_cnt-1 (0..4)
//   push_data    one word of pixels, same packing as the repacker input
//   head         oldest four slots of the buffer
//   cnt          occupancy in pixels
// The caller guarantees the push never exceeds BUF_PIXS; BUF_PIXS >= 4.
// -----------------------------------------------------------------------------
module pix_shift_buf
   import pixel_repacker_pkg::*;
#(
   parameter  int BUF_PIXS = 12,
   localparam int CNT_W    = $clog2(BUF_PIXS + 1)
) (
   input  logic                 clk_out_int,
   input  logic                 rst_n,
   input  logic                 clr,
   input  pix_num_t             pop_cnt,
   input  pix_num_t             push_cnt,
   input  logic [WORD_BITS-1:0] push_data,
   output logic [WORD_BITS-1:0] head,
   output logic [CNT_W-1:0]     cnt
);

   localparam int BUF_BITS = BUF_PIXS * PIX_W;

   logic [BUF_BITS-1:0]  buf_q;
   logic [BUF_BITS-1:0]  buf_d;
   logic [BUF_BITS-1:0]  shifted;
   logic [BUF_BITS-1:0]  push_vec;
   logic [WORD_BITS-1:0] data_msk;
   logic [CNT_W-1:0]     keep;
   logic [CNT_W-1:0]     cnt_d;

   // Slots at and above cnt are always zero, so the appended pixels can be
   // OR-merged into the shifted survivors without a per-slot mux.
   always_comb begin
      // NOTE: every variable gets a value before any condition so no latch is inferred.
      data_msk = '0;
      keep     = clr ? '0 : cnt - CNT_W'(pop_cnt);
      shifted  = clr ? '0 : buf_q >> (int'(pop_cnt) * PIX_W);
      for (int p = 0; p < PIXS_PER_WORD; p++) begin
         if (p < int'(push_cnt)) data_msk[p*PIX_W +: PIX_W] = '1;
      end
      push_vec = BUF_BITS'(push_data & data_msk) << (int'(keep) * PIX_W);
      buf_d    = shifted | push_vec;
      cnt_d    = keep + CNT_W'(push_cnt);
   end

   // NOTE: the pixel slots are reset too, because the OR-merge above relies on empty slots being zero.
   always_ff @(posedge clk_out_int or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         buf_q <= '0;
         cnt   <= '0;
      end else begin
         buf_q <= buf_d;
         cnt   <= cnt_d;
      end
   end

   assign head = buf_q[WORD_BITS-1:0];

endmodule

// File: rtl/pixel_repacker.sv
// -----------------------------------------------------------------------------
// pixel_repacker
// Output stage in the clk_out_int domain. Compacts 4-pixel words with partial
// masks into dense words and regenerates line/frame boundaries from
// frame_width/frame_height: every line is gap-free, only its last word may be
// partial, and that word carries EOL (plus EOF on the last line).
//
// Ports:
//   clk_out_int     pixel output clock
//   rst_n           asynchronous active-low reset
//   flush           synchronous clear of all state (beats SOF and data)
//   frame_width     pixels per line, 1..MAX_FRAME_WIDTH
//   frame_height    lines per frame, >= 1
//   pixs_in         4 pixels x 3 comps x 14 b, pixel p comp c at [(p*3+c)*14 +: 14]
//   pixs_in_valid   input mask, legal 0000/0001/0011/0111/1111
//   pixs_in_sof     start of frame: clears buffer, counters and error flags
//   pixs_out        compacted pixels, unused slots zero
//   pixs_out_valid  output mask, 1111 except on the last word of a line
//   pixs_out_sof    first output word of the frame
//   pixs_out_eol    last word of each line
//   pixs_out_eof    last word of the frame
//   err_mask        sticky: non-contiguous input mask seen
//   err_overflow    sticky: input word dropped because the buffer was full
// -----------------------------------------------------------------------------
module pixel_repacker
   import pixel_repacker_pkg::*;
#(
   parameter int MAX_FRAME_WIDTH = 5120,
   parameter int BUF_PIXS        = 12
) (
   input  logic                 clk_out_int,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic [15:0]          frame_width,
   input  logic [15:0]          frame_height,
   input  logic [WORD_BITS-1:0] pixs_in,
   input  logic [3:0]           pixs_in_valid,
   input  logic                 pixs_in_sof,
   output logic [WORD_BITS-1:0] pixs_out,
   output logic [3:0]           pixs_out_valid,
   output logic                 pixs_out_sof,
   output logic                 pixs_out_eol,
   output logic                 pixs_out_eof,
   output logic                 err_mask,
   output logic                 err_overflow
);

   localparam int PC_W  = $clog2(MAX_FRAME_WIDTH + 1);
   localparam int CNT_W = $clog2(BUF_PIXS + 1);

   logic [PC_W-1:0]      pix_cnt;
   logic [15:0]          line_cnt;
   logic                 sof_pend;

   logic [CNT_W-1:0]     buf_cnt;
   logic [WORD_BITS-1:0] head;

   mask_info_t           in_info;
   logic                 clr;
   logic [15:0]          rem;
   pix_num_t             need;
   logic                 emit;
   logic                 end_line;
   logic                 end_frame;
   int                   after_emit;
   logic                 drop;
   pix_num_t             pop_cnt;
   pix_num_t             push_cnt;
   logic [WORD_BITS-1:0] out_d;
   logic [3:0]           valid_d;

   pix_shift_buf #(
      .BUF_PIXS (BUF_PIXS)
   ) u_buf (
      .clk_out_int (clk_out_int),
      .rst_n       (rst_n),
      .clr         (clr),
      .pop_cnt     (pop_cnt),
      .push_cnt    (push_cnt),
      .push_data   (pixs_in),
      .head        (head),
      .cnt         (buf_cnt)
   );

   // Emit decision on the pre-append buffer. During SOF or flush the buffer
   // is cleared first, so nothing can be emitted in that cycle.
   always_comb begin
      in_info    = mask_to_cnt(pixs_in_valid);
      clr        = flush | pixs_in_sof;
      rem        = frame_width - 16'(pix_cnt);
      need       = (rem > 16'd4) ? 3'd4 : rem[2:0];
      emit       = !clr && (need != 3'd0) && (int'(buf_cnt) >= int'(need));
      end_line   = emit && (rem == 16'(need));
      end_frame  = end_line && (line_cnt == frame_height - 16'd1);
      pop_cnt    = emit ? need : 3'd0;

      // Overflow is judged against the occupancy left after this cycle's emit.
      after_emit = clr ? 0 : int'(buf_cnt) - int'(pop_cnt);
      drop       = !flush && (after_emit + int'(in_info.n) > BUF_PIXS);
      push_cnt   = (flush || drop) ? 3'd0 : in_info.n;

      out_d = '0;
      for (int p = 0; p < PIXS_PER_WORD; p++) begin
         if (emit && p < int'(need)) out_d[p*PIX_W +: PIX_W] = head[p*PIX_W +: PIX_W];
      end
      valid_d = emit ? 4'((5'd1 << need) - 5'd1) : 4'd0;
   end

   always_ff @(posedge clk_out_int or negedge rst_n) begin
      if (!rst_n) begin
         pixs_out       <= '0;
         pixs_out_valid <= '0;
         pixs_out_sof   <= 1'b0;
         pixs_out_eol   <= 1'b0;
         pixs_out_eof   <= 1'b0;
         err_mask       <= 1'b0;
         err_overflow   <= 1'b0;
         pix_cnt        <= '0;
         line_cnt       <= '0;
         sof_pend       <= 1'b0;
      end else if (flush) begin
         pixs_out       <= '0;
         pixs_out_valid <= '0;
         pixs_out_sof   <= 1'b0;
         pixs_out_eol   <= 1'b0;
         pixs_out_eof   <= 1'b0;
         err_mask       <= 1'b0;
         err_overflow   <= 1'b0;
         pix_cnt        <= '0;
         line_cnt       <= '0;
         sof_pend       <= 1'b0;
      end else begin
         pixs_out       <= out_d;
         pixs_out_valid <= valid_d;
         pixs_out_sof   <= emit & sof_pend;
         pixs_out_eol   <= end_line;
         pixs_out_eof   <= end_frame;

         if (pixs_in_sof) begin
            // Clear first; a word arriving with SOF is the new frame's first.
            pix_cnt      <= '0;
            line_cnt     <= '0;
            sof_pend     <= 1'b1;
            err_mask     <= in_info.illegal;
            err_overflow <= drop;
         end else begin
            if (emit) begin
               sof_pend <= 1'b0;
               if (end_line) begin
                  pix_cnt  <= '0;
                  line_cnt <= end_frame ? 16'd0 : line_cnt + 16'd1;
               end else begin
                  pix_cnt  <= pix_cnt + PC_W'(need);
               end
            end
            if (in_info.illegal) err_mask     <= 1'b1;
            if (drop)            err_overflow <= 1'b1;
         end
      end
   end

endmodule
